axi_burst_rd_slave: RTL and testbench

AXI4 read-only burst responder: the memory-side end of the icache refill channel. It accepts AR requests (FIXED/INCR/WRAP bursts) and returns R beats from an internal word array after a programmable latency, with rlast on the final beat. Serves as the instruction memory model behind the icache in simulation. A side load port lets the bench or boot logic preload the array.

---
 rtl/axi_burst_rd_slave_if.sv | 22 ++
 rtl/axi_burst_rd_slave.sv | 107 ++++++++++
 tb/tb_axi_burst_rd_slave.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_rd_slave_if.sv
// axi_burst_rd_slave_if: AXI4 read address/data channel bundle for the burst read slave
interface axi_burst_rd_slave_if;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  modport slave (
    input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast
  );
  modport master (
    output s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast
  );
endinterface

// File: rtl/axi_burst_rd_slave.sv
// axi_burst_rd_slave: AXI4 read burst responder serving beats from a preloadable word array
module axi_burst_rd_slave #(
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
  parameter int          MEM_WORDS  = 1024,
  parameter int          RD_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_burst_rd_slave_if.slave          s,
  input  logic                         ld_we,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
  input  logic [31:0]                  ld_data
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, nxt_addr, beat_addr, off, step, bytes, incr_addr, wrap_addr;
  logic [7:0] len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [2:0] size_q, size_d;
  logic [1:0] burst_q, burst_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;
  logic ar_hs, r_hs, load_beat, slverr, in_rng;
  logic [31:0] mem [MEM_WORDS];
  assign ar_hs = state_q == IDLE && s.s_arvalid && arready_q;
  assign r_hs = state_q == BEAT && rvalid_q && s.s_rready;
  assign load_beat = (state_q == WAIT && lat_cnt_q == '0) || (r_hs && !rlast_q);
  assign s.s_arready = arready_q;
  assign s.s_rvalid = rvalid_q;
  assign s.s_rdata = rdata_q;
  assign s.s_rresp = rresp_q;
  assign s.s_rlast = rlast_q;
  // Beat address generation and per-beat response classification
  always_comb begin
    step = 32'd1 << size_q;
    bytes = ({24'd0, len_q} + 32'd1) << size_q;
    incr_addr = addr_q + step;
    wrap_addr = (addr_q & ~(bytes - 32'd1)) | (incr_addr & (bytes - 32'd1));
    nxt_addr = burst_q == 2'b00 ? addr_q : burst_q == 2'b10 ? wrap_addr : incr_addr;
    beat_addr = state_q == WAIT ? addr_q : nxt_addr;
    off = beat_addr - ADDR_BASE;
    in_rng = off < 32'(4 * MEM_WORDS);
    slverr = size_q > 3'd2 || burst_q == 2'b11 ||
             (burst_q == 2'b10 && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Next-state: accept AR, count down latency, stream beats until rlast handshake
  always_comb begin
    state_d = ar_hs ? WAIT :
              (state_q == WAIT && lat_cnt_q == '0) ? BEAT :
              (r_hs && rlast_q) ? IDLE : state_q;
  end
  // Datapath and registered R-channel next values
  always_comb begin
    addr_d = ar_hs ? s.s_araddr : (r_hs && !rlast_q) ? nxt_addr : addr_q;
    len_d = ar_hs ? s.s_arlen : len_q;
    size_d = ar_hs ? s.s_arsize : size_q;
    burst_d = ar_hs ? s.s_arburst : burst_q;
    beat_cnt_d = ar_hs ? 8'd0 : (r_hs && !rlast_q) ? beat_cnt_q + 8'd1 : beat_cnt_q;
    lat_cnt_d = ar_hs ? LW'(RD_LATENCY - 1) :
                (state_q == WAIT && lat_cnt_q != '0) ? lat_cnt_q - LW'(1) : lat_cnt_q;
    arready_d = state_q == IDLE ? !ar_hs : (r_hs && rlast_q);
    rvalid_d = load_beat || (rvalid_q && !(r_hs && rlast_q));
    rlast_d = load_beat ? beat_cnt_d == len_q : r_hs ? 1'b0 : rlast_q;
    rdata_d = !load_beat ? rdata_q : (slverr || !in_rng) ? 32'd0 : mem[off[AW+1:2]];
    rresp_d = !load_beat ? rresp_q : slverr ? 2'b10 : !in_rng ? 2'b11 : 2'b00;
  end
  // Burst context and R-channel registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      beat_cnt_q <= '0;
      lat_cnt_q <= '0;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      burst_q <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end
  // Preload port; array survives reset
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
  end
endmodule

// File: tb/tb_axi_burst_rd_slave.sv
// tb_axi_burst_rd_slave: scoreboard bench for the AXI burst read slave
module tb_axi_burst_rd_slave;
  typedef struct packed {logic [31:0] d; logic [1:0] r; logic l;} beat_t;
  logic clk = 0, rst = 1, ld_we = 0;
  logic [9:0] ld_addr = 0;
  logic [31:0] ld_data = 0;
  int chk = 0, pass = 0;
  beat_t exp_q[$];
  axi_burst_rd_slave_if bus();
  axi_burst_rd_slave dut (.clk(clk), .rst(rst), .s(bus), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  task automatic push(input logic [31:0] d, input logic [1:0] r, input logic l);
    beat_t b;
    b = {d, r, l};
    exp_q.push_back(b);
  endtask
  task automatic load(input int idx, input logic [31:0] d);
    @(negedge clk);
    ld_we = 1;
    ld_addr = 10'(idx);
    ld_data = d;
    @(negedge clk);
    ld_we = 0;
  endtask
  task automatic issue(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
    int t = 0;
    @(negedge clk);
    bus.s_arvalid = 1;
    bus.s_araddr = a;
    bus.s_arlen = len;
    bus.s_arsize = sz;
    bus.s_arburst = bt;
    while (!bus.s_arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk++;
    if (bus.s_arready !== 1'b1) $display("FAIL ar_handshake: arready=%b required 1", bus.s_arready);
    else pass++;
    @(posedge clk);
    #1 bus.s_arvalid = 0;
  endtask
  task automatic collect(input int n, input bit stall, output int lat, output int unstable,
                         output logic ar_after, output logic rv_after);
    int got = 0, cyc = 0, vc = 0;
    bit seen = 0, held = 0;
    beat_t prev, o, e;
    lat = 0;
    unstable = 0;
    prev = '0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      o = {bus.s_rdata, bus.s_rresp, bus.s_rlast};
      if (held && (!bus.s_rvalid || o !== prev)) unstable++;
      if (!bus.s_rvalid && !seen) lat++;
      bus.s_rready = stall ? (vc % 4 == 0 || vc % 4 == 3) : 1'b1;
      if (bus.s_rvalid) begin
        seen = 1;
        vc++;
      end
      held = bus.s_rvalid && !bus.s_rready;
      prev = o;
      if (bus.s_rvalid && bus.s_rready) begin
        got++;
        e = '1;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk++;
        if (o !== e)
          $display("FAIL beat%0d: got d=%h r=%b l=%b required d=%h r=%b l=%b", got, o.d, o.r, o.l, e.d, e.r, e.l);
        else pass++;
      end
    end
    chk++;
    if (got != n) $display("FAIL beat_count: got %0d beats required %0d", got, n);
    else pass++;
    @(negedge clk);
    ar_after = bus.s_arready;
    rv_after = bus.s_rvalid;
    bus.s_rready = 0;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    chk++; if (bus.s_arready !== 1'b0) $display("FAIL rst_arready: got %b required 0", bus.s_arready); else pass++;
    chk++; if (bus.s_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b required 0", bus.s_rvalid); else pass++;
    chk++; if (bus.s_rdata !== 32'd0) $display("FAIL rst_rdata: got %h required 0", bus.s_rdata); else pass++;
    chk++; if (bus.s_rresp !== 2'b00) $display("FAIL rst_rresp: got %b required 00", bus.s_rresp); else pass++;
    chk++; if (bus.s_rlast !== 1'b0) $display("FAIL rst_rlast: got %b required 0", bus.s_rlast); else pass++;
    rst = 0;
    @(negedge clk);
    chk++; if (bus.s_arready !== 1'b1) $display("FAIL rst_release_arready: got %b required 1", bus.s_arready); else pass++;
  endtask
  task automatic test_incr;
    int lat, uns;
    logic ar, rv;
    push(32'h11, 2'b00, 0); push(32'h22, 2'b00, 0); push(32'h33, 2'b00, 0); push(32'h44, 2'b00, 1);
    issue(32'h3000_0000, 8'd3, 3'd2, 2'b01);
    collect(4, 0, lat, uns, ar, rv);
    chk++; if (lat !== 2) $display("FAIL incr_latency: got %0d required 2", lat); else pass++;
    chk++; if (ar !== 1'b1) $display("FAIL incr_arready_after: got %b required 1", ar); else pass++;
    chk++; if (rv !== 1'b0) $display("FAIL incr_rvalid_after: got %b required 0", rv); else pass++;
  endtask
  task automatic test_stall;
    int lat, uns;
    logic ar, rv;
    push(32'h11, 2'b00, 0); push(32'h22, 2'b00, 0); push(32'h33, 2'b00, 0); push(32'h44, 2'b00, 1);
    issue(32'h3000_0000, 8'd3, 3'd2, 2'b01);
    collect(4, 1, lat, uns, ar, rv);
    chk++; if (uns !== 0) $display("FAIL stall_stable: got %0d changes required 0", uns); else pass++;
    chk++; if (exp_q.size() !== 0) $display("FAIL stall_drain: got %0d left required 0", exp_q.size()); else pass++;
  endtask
  task automatic test_wrap;
    int lat, uns;
    logic ar, rv;
    push(32'h33, 2'b00, 0); push(32'h44, 2'b00, 0); push(32'h11, 2'b00, 0); push(32'h22, 2'b00, 1);
    issue(32'h3000_0008, 8'd3, 3'd2, 2'b10);
    collect(4, 0, lat, uns, ar, rv);
    push(32'h22, 2'b00, 0); push(32'h22, 2'b00, 0); push(32'h22, 2'b00, 1);
    issue(32'h3000_0004, 8'd2, 3'd2, 2'b00);
    collect(3, 0, lat, uns, ar, rv);
    chk++; if (ar !== 1'b1) $display("FAIL fixed_arready_after: got %b required 1", ar); else pass++;
  endtask
  task automatic test_errors;
    int lat, uns;
    logic ar, rv;
    push(32'h0, 2'b11, 1);
    issue(32'h3000_1000, 8'd0, 3'd2, 2'b01);
    collect(1, 0, lat, uns, ar, rv);
    push(32'h0, 2'b10, 1);
    issue(32'h3000_0000, 8'd0, 3'd3, 2'b01);
    collect(1, 0, lat, uns, ar, rv);
    push(32'h0, 2'b10, 0); push(32'h0, 2'b10, 0); push(32'h0, 2'b10, 1);
    issue(32'h3000_0000, 8'd2, 3'd2, 2'b10);
    collect(3, 0, lat, uns, ar, rv);
    push(32'h0, 2'b10, 0); push(32'h0, 2'b10, 1);
    issue(32'h3000_0000, 8'd1, 3'd2, 2'b11);
    collect(2, 0, lat, uns, ar, rv);
    push(32'h0, 2'b11, 0); push(32'h11, 2'b00, 1);
    issue(32'h2FFF_FFFC, 8'd1, 3'd2, 2'b01);
    collect(2, 0, lat, uns, ar, rv);
    load(1023, 32'h99);
    push(32'h99, 2'b00, 0); push(32'h0, 2'b11, 1);
    issue(32'h3000_0FFC, 8'd1, 3'd2, 2'b01);
    collect(2, 0, lat, uns, ar, rv);
    chk++; if (ar !== 1'b1) $display("FAIL err_arready_after: got %b required 1", ar); else pass++;
  endtask
  task automatic test_reset_mid;
    int t = 0, lat, uns;
    logic ar, rv;
    issue(32'h3000_0000, 8'd3, 3'd2, 2'b01);
    bus.s_rready = 1;
    @(negedge clk);
    while (!bus.s_rvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk++; if (bus.s_rdata !== 32'h11) $display("FAIL mid_beat1: got %h required 11", bus.s_rdata); else pass++;
    @(negedge clk);
    chk++; if (bus.s_rdata !== 32'h22) $display("FAIL mid_beat2: got %h required 22", bus.s_rdata); else pass++;
    rst = 1;
    bus.s_rready = 0;
    @(negedge clk);
    chk++;
    if ({bus.s_arready, bus.s_rvalid, bus.s_rdata, bus.s_rresp, bus.s_rlast} !== 37'd0)
      $display("FAIL mid_reset_outputs: got ar=%b rv=%b d=%h r=%b l=%b required all 0",
               bus.s_arready, bus.s_rvalid, bus.s_rdata, bus.s_rresp, bus.s_rlast);
    else pass++;
    rst = 0;
    @(negedge clk);
    chk++; if (bus.s_arready !== 1'b1) $display("FAIL mid_arready: got %b required 1", bus.s_arready); else pass++;
    push(32'h11, 2'b00, 0); push(32'h22, 2'b00, 0); push(32'h33, 2'b00, 0); push(32'h44, 2'b00, 1);
    issue(32'h3000_0000, 8'd3, 3'd2, 2'b01);
    collect(4, 0, lat, uns, ar, rv);
  endtask
  task automatic test_back_to_back;
    int lat, uns;
    logic ar, rv;
    push(32'h33, 2'b00, 0); push(32'h44, 2'b00, 1);
    issue(32'h3000_0008, 8'd1, 3'd2, 2'b01);
    collect(2, 0, lat, uns, ar, rv);
    push(32'h44, 2'b00, 1);
    issue(32'h3000_000C, 8'd0, 3'd2, 2'b01);
    collect(1, 0, lat, uns, ar, rv);
    chk++; if (lat !== 2) $display("FAIL b2b_latency: got %0d required 2", lat); else pass++;
  endtask
  task automatic test_preload_collision;
    int lat, uns;
    logic ar, rv;
    push(32'h11, 2'b00, 0); push(32'h22, 2'b00, 0); push(32'h33, 2'b00, 0); push(32'h44, 2'b00, 1);
    issue(32'h3000_0000, 8'd3, 3'd2, 2'b01);
    fork
      collect(4, 0, lat, uns, ar, rv);
      begin
        repeat (3) @(negedge clk);
        ld_we = 1;
        ld_addr = 10'd1;
        ld_data = 32'hAA;
        @(negedge clk);
        ld_we = 0;
      end
    join
    push(32'h11, 2'b00, 0); push(32'hAA, 2'b00, 0); push(32'h33, 2'b00, 0); push(32'h44, 2'b00, 1);
    issue(32'h3000_0000, 8'd3, 3'd2, 2'b01);
    collect(4, 0, lat, uns, ar, rv);
    chk++; if (exp_q.size() !== 0) $display("FAIL final_drain: got %0d left required 0", exp_q.size()); else pass++;
  endtask
  initial begin
    bus.s_arvalid = 0;
    bus.s_araddr = 0;
    bus.s_arlen = 0;
    bus.s_arsize = 0;
    bus.s_arburst = 0;
    bus.s_rready = 0;
    test_reset;
    load(0, 32'h11);
    load(1, 32'h22);
    load(2, 32'h33);
    load(3, 32'h44);
    test_incr;
    test_stall;
    test_wrap;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    test_preload_collision;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
